// File: rtl/phase_a_pkg.sv
// rtl/phase_a_pkg.sv - shared types and constants for the phase_a sequencer
package phase_a_pkg;

  // Datapath geometry shared with the phase_a instance
  localparam int PA_SIZE  = 3072;
  localparam int PA_RADIX = 72;

  // Default sequencer configuration
  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ITER_W  = 6;
  localparam int DEF_TMO_W   = 10;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } pa_state_e;

endpackage

// File: rtl/phase_a_sched_rr_arbiter.sv
// rtl/phase_a_sched_rr_arbiter.sv - combinational round-robin pick; pointer is held by the caller
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int pos;

  // Scan starting one past the last winner; the first active requester wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!any && req[pos[IW-1:0]]) begin
        gnt[pos[IW-1:0]] = 1'b1;
        idx              = pos[IW-1:0];
        any              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_a_sched.sv
// rtl/phase_a_sched.sv - job sequencer and round-robin arbiter for phase_a (watchdog: PHASE_A_SCHED_TIMEOUT_EN)
module phase_a_sched
  import phase_a_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ITER_W  = DEF_ITER_W,
  parameter int TMO_W   = DEF_TMO_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ITER_W-1:0]    req_iters,
  output logic                         pa_en,
  output logic                         pa_if_last,
  output logic                         pa_fb,
  output logic [$clog2(NUM_REQ)-1:0]   pa_gnt,
  input  logic                         pa_en_out,
  output logic                         done_valid,
  output logic [$clog2(NUM_REQ)-1:0]   done_id,
  output logic                         done_err
);

  localparam int IDW = $clog2(NUM_REQ);

  pa_state_e         state_q, state_d;
  logic [ITER_W-1:0] rem_q, rem_d;
  logic [IDW-1:0]    gnt_q, gnt_d;
  logic              fb_q, fb_d;
  logic [IDW-1:0]    ptr_q, ptr_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDW-1:0]     arb_idx;
  logic               arb_any;
  logic [ITER_W-1:0]  win_iters;

`ifdef PHASE_A_SCHED_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign win_iters = req_iters[arb_idx*ITER_W +: ITER_W];
  assign pa_gnt    = gnt_q;
  assign pa_fb     = fb_q;

  // Next-state and output decode; accept only in IDLE, chain passes until rem runs out
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    gnt_d      = gnt_q;
    fb_d       = fb_q;
    ptr_d      = ptr_q;
    req_ready  = '0;
    pa_en      = 1'b0;
    pa_if_last = 1'b0;
    done_valid = 1'b0;
    done_id    = '0;
    done_err   = 1'b0;
`ifdef PHASE_A_SCHED_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // rst gating keeps ready low while reset is held with requests pending
        req_ready = rst ? '0 : arb_gnt;
        if (arb_any && !rst) begin
          gnt_d   = arb_idx;
          rem_d   = (win_iters == '0) ? ITER_W'(1) : win_iters;
          fb_d    = 1'b0;
          ptr_d   = arb_idx;
          state_d = ST_ISSUE;
`ifdef PHASE_A_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_ISSUE: begin
        pa_en      = 1'b1;
        pa_if_last = (rem_q == ITER_W'(1));
        state_d    = ST_WAIT;
`ifdef PHASE_A_SCHED_TIMEOUT_EN
        tmo_d      = '0;
`endif
      end
      ST_WAIT: begin
        if (pa_en_out) begin
          if (rem_q != '0) begin
            rem_d = rem_q - ITER_W'(1);
          end
          if (rem_q > ITER_W'(1)) begin
            fb_d    = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
          end
        end
`ifdef PHASE_A_SCHED_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (&tmo_d) begin
            err_d   = 1'b1;
            rem_d   = '0;
            state_d = ST_DONE;
          end
        end
`endif
      end
      ST_DONE: begin
        done_valid = 1'b1;
        done_id    = gnt_q;
`ifdef PHASE_A_SCHED_TIMEOUT_EN
        done_err   = err_q;
`endif
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; pointer resets to the last slot so requester 0 wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      gnt_q   <= '0;
      fb_q    <= 1'b0;
      ptr_q   <= IDW'(NUM_REQ - 1);
`ifdef PHASE_A_SCHED_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gnt_q   <= gnt_d;
      fb_q    <= fb_d;
      ptr_q   <= ptr_d;
`ifdef PHASE_A_SCHED_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_phase_a_sched.sv
// tb/tb_phase_a_sched.sv - self-checking bench for phase_a_sched (timeout case under PHASE_A_SCHED_TIMEOUT_EN)
module tb_phase_a_sched;

  localparam int NUM_REQ = 2;
  localparam int ITER_W  = 6;
  localparam int TMO_W   = 4;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ITER_W-1:0] req_iters;
  logic                      pa_en;
  logic                      pa_if_last;
  logic                      pa_fb;
  logic [0:0]                pa_gnt;
  logic                      pa_en_out;
  logic                      done_valid;
  logic [0:0]                done_id;
  logic                      done_err;

  phase_a_sched #(
    .NUM_REQ (NUM_REQ),
    .ITER_W  (ITER_W),
    .TMO_W   (TMO_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_iters  (req_iters),
    .pa_en      (pa_en),
    .pa_if_last (pa_if_last),
    .pa_fb      (pa_fb),
    .pa_gnt     (pa_gnt),
    .pa_en_out  (pa_en_out),
    .done_valid (done_valid),
    .done_id    (done_id),
    .done_err   (done_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mdl_ptr;          // last winner according to the reference model
  int grant_log[$];
  int done_log[$];

  typedef struct {
    int id;
    int iters;
    int lat;
    int exp_passes;
    int exp_id;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {23'd0, req_ready, pa_en, pa_if_last, pa_fb, pa_gnt, done_valid, done_id, done_err};
  endfunction

  // One isolated job on one requester, responding to every pass after lat WAIT cycles
  task automatic run_job(input vec_t v);
    int w;
    req_iters[v.id*ITER_W +: ITER_W] = ITER_W'(v.iters);
    req_valid = NUM_REQ'(1 << v.id);
    #2;
    w = 0;
    while (req_ready !== NUM_REQ'(1 << v.id) && w < 10) begin
      tick(); #2; w++;
    end
    chk("job_ready", req_ready, 1 << v.id);
    mdl_ptr = v.id;
    tick();
    req_valid = '0;
    #2;
    for (int p = 0; p < v.exp_passes; p++) begin
      chk("job_en", pa_en, 1);
      chk("job_if_last", pa_if_last, (p == v.exp_passes - 1));
      chk("job_fb", pa_fb, (p > 0));
      chk("job_gnt", pa_gnt, v.exp_id);
      for (int l = 0; l < v.lat; l++) begin
        tick(); #2;
        chk("job_wait_quiet", {pa_en, done_valid}, 0);
      end
      tick();
      pa_en_out = 1'b1;
      #2;
      chk("job_eo_quiet", {pa_en, done_valid}, 0);
      tick();
      pa_en_out = 1'b0;
      #2;
    end
    chk("job_done", done_valid, 1);
    chk("job_done_id", done_id, v.exp_id);
    chk("job_done_err", done_err, 0);
    chk("job_done_no_en", pa_en, 0);
    tick(); #2;
    chk("job_done_single", done_valid, 0);
  endtask

  // Cycle-level scoreboard: jobs are tracked as event timestamps, not FSM states
  task automatic engine(input int ncyc, input bit contend, input int want_grants);
    bit pend[NUM_REQ];
    int piters[NUM_REQ];
    bit busy = 0;
    int next_en = -1, eo_c = -1, done_c = -1;
    int left = 0, pass_i = 0, job_id = 0, win, c = 0, ngr = 0;
    bit stray, active, exp_en, exp_done;
    grant_log.delete();
    done_log.delete();
    for (int i = 0; i < NUM_REQ; i++) begin pend[i] = 0; piters[i] = 0; end
    while ((c < ncyc || busy) && c < ncyc + 400) begin
      active = (c < ncyc) && (ngr < want_grants);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!active) pend[i] = 0;
        else if (contend) begin pend[i] = 1; piters[i] = 2; end
        else if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1; piters[i] = $urandom_range(0, 4);
        end else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 0;
        req_valid[i] = pend[i];
        req_iters[i*ITER_W +: ITER_W] = ITER_W'(piters[i]);
      end
      stray = !busy || (c == next_en) || (c == done_c);
      pa_en_out = (busy && c == eo_c) ? 1'b1 : (stray && !contend && $urandom_range(0, 7) == 0);
      #2;
      win = -1;
      if (!busy)
        for (int k = 1; k <= NUM_REQ; k++)
          if (win < 0 && pend[(mdl_ptr + k) % NUM_REQ]) win = (mdl_ptr + k) % NUM_REQ;
      chk("rnd_ready", req_ready, (win >= 0) ? (1 << win) : 0);
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) grant_log.push_back(i);
      exp_en = busy && (c == next_en);
      chk("rnd_en", pa_en, exp_en);
      if (exp_en) begin
        chk("rnd_if_last", pa_if_last, (left == 1));
        chk("rnd_fb", pa_fb, (pass_i > 0));
        chk("rnd_gnt", pa_gnt, job_id);
      end
      exp_done = busy && (c == done_c);
      chk("rnd_done", done_valid, exp_done);
      if (done_valid) done_log.push_back(int'(done_id));
      if (exp_done) begin
        chk("rnd_done_id", done_id, job_id);
        chk("rnd_done_err", done_err, 0);
      end
      if (exp_en) begin
        eo_c = c + 1 + (contend ? 2 : $urandom_range(0, 4));
        next_en = -1;
      end
      if (busy && c == eo_c) begin
        left--; pass_i++; eo_c = -1;
        if (left > 0) next_en = c + 1; else done_c = c + 1;
      end
      if (exp_done) begin busy = 0; done_c = -1; end
      if (win >= 0) begin
        busy = 1; job_id = win; mdl_ptr = win; ngr++;
        left = (piters[win] == 0) ? 1 : piters[win];
        pass_i = 0; next_en = c + 1; pend[win] = 0;
      end
      tick();
      c++;
    end
    chk("rnd_drained", busy, 0);
    req_valid = '0;
    pa_en_out = 1'b0;
  endtask

  vec_t vt[5];
  int exp_seq[4];
  int cnt;

  initial begin
    #500000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vt[0] = '{id: 0, iters: 1, lat: 5, exp_passes: 1, exp_id: 0};
    vt[1] = '{id: 0, iters: 3, lat: 2, exp_passes: 3, exp_id: 0};
    vt[2] = '{id: 1, iters: 0, lat: 3, exp_passes: 1, exp_id: 1};
    vt[3] = '{id: 0, iters: 5, lat: 1, exp_passes: 5, exp_id: 0};
    vt[4] = '{id: 1, iters: 2, lat: 0, exp_passes: 2, exp_id: 1};
    exp_seq = '{0, 1, 0, 1};

    rst = 1'b1;
    req_valid = '0;
    req_iters = '0;
    pa_en_out = 1'b0;
    mdl_ptr = NUM_REQ - 1;
    tick(); #2;
    chk("reset_outs", all_outs(), 0);
    tick();
    rst = 1'b0;
    #2;
    chk("post_reset_outs", all_outs(), 0);

    for (int i = 0; i < 5; i++) run_job(vt[i]);

    // Stray en_out in IDLE must not start or finish anything
    tick();
    pa_en_out = 1'b1;
    #2;
    chk("stray_same", {pa_en, done_valid}, 0);
    tick();
    pa_en_out = 1'b0;
    #2;
    chk("stray_next", {pa_en, done_valid}, 0);
    tick(); #2;
    chk("stray_later", {pa_en, done_valid}, 0);

    // Contention: both held, two passes each
    engine(200, 1'b1, 4);
    chk("cont_grants", grant_log.size(), 4);
    chk("cont_dones", done_log.size(), 4);
    for (int j = 0; j < 4; j++) begin
      if (j < grant_log.size()) chk("cont_grant_order", grant_log[j], exp_seq[j]);
      if (j < done_log.size()) chk("cont_done_order", done_log[j], exp_seq[j]);
    end

    engine(3000, 1'b0, 1000000);

    // Reset during WAIT of the second pass of a 4-pass job
    req_iters[0 +: ITER_W] = ITER_W'(4);
    req_valid = 2'b01;
    #2;
    chk("rmw_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    #2;
    chk("rmw_en1", pa_en, 1);
    tick();
    pa_en_out = 1'b1;
    #2;
    tick();
    pa_en_out = 1'b0;
    #2;
    chk("rmw_en2", pa_en, 1);
    tick(); #2;
    chk("rmw_wait_fb", pa_fb, 1);
    req_valid = 2'b11;
    req_iters = {ITER_W'(1), ITER_W'(1)};
    rst = 1'b1;
    #1;
    chk("rmw_outs_zero", all_outs(), 0);
    for (int i = 0; i < 3; i++) begin
      tick(); #2;
      chk("rmw_held", all_outs(), 0);
    end
    rst = 1'b0;
    mdl_ptr = NUM_REQ - 1;
    #2;
    chk("rmw_first_grant", req_ready, 2'b01);
    tick();
    req_valid = '0;
    #2;
    chk("rmw_new_en", pa_en, 1);
    chk("rmw_new_gnt", pa_gnt, 0);
    tick();
    pa_en_out = 1'b1;
    #2;
    tick();
    pa_en_out = 1'b0;
    #2;
    chk("rmw_new_done", done_valid, 1);
    chk("rmw_new_done_id", done_id, 0);
    mdl_ptr = 0;
    tick(); #2;

`ifdef PHASE_A_SCHED_TIMEOUT_EN
    // Watchdog: no en_out ever; done with error after 15 WAIT cycles
    req_iters[ITER_W +: ITER_W] = ITER_W'(3);
    req_valid = 2'b10;
    #2;
    chk("tmo_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    #2;
    chk("tmo_en", pa_en, 1);
    cnt = 0;
    do begin
      tick(); #2; cnt++;
    end while (!done_valid && cnt < 40);
    chk("tmo_cycles", cnt, 16);
    chk("tmo_done", done_valid, 1);
    chk("tmo_err", done_err, 1);
    chk("tmo_id", done_id, 1);
    tick();
    req_valid = 2'b01;
    #2;
    chk("tmo_idle_again", req_ready, 2'b01);
    req_valid = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
